// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read and write sides: default sizes,
// count-width sizing and the wrapping pointer increment.
package fifo_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int OUT_DEPTH_DEF  = 3;

    // Bits needed to hold a count from 0 up to and including depth.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Explicit wrap keeps non-power-of-2 depths legal.
    function automatic int ptr_wrap(input int ptr, input int depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_out_buf.sv
// Small circular register buffer: push at tail, pop at head, occupancy count
// and the head word presented directly from storage.
module fifo_out_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = OUT_DEPTH_DEF,
    parameter int CNT_W      = cnt_width(DEPTH)
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [CNT_W-1:0]      count,
    output logic [DATA_WIDTH-1:0] head_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;

    always_ff @(posedge rd_clk or negedge rd_rst) begin
        if (!rd_rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= PTR_W'(ptr_wrap(int'(tail), DEPTH));
            end
            if (pop) begin
                head <= PTR_W'(ptr_wrap(int'(head), DEPTH));
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Storage needs no reset; only entries between head and tail are ever read.
    always_ff @(posedge rd_clk) begin
        if (push) begin
            store[tail] <= push_data;
        end
    end

    assign head_data = store[head];

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read-side output stage: issues RAM reads against buffer credit and
// presents captured words as a registered first-word-fall-through stream.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int OUT_DEPTH  = OUT_DEPTH_DEF,
    parameter int CNT_W      = cnt_width(OUT_DEPTH)
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [CNT_W-1:0]      out_level
);

    logic             inflight;
    logic [CNT_W-1:0] count;
    logic [CNT_W:0]   pending;
    logic             pop;

    // Credit counts the word still coming out of the RAM so a capture always has room.
    assign pending    = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
    assign fifo_rd_en = !fifo_empty && (pending < (CNT_W + 1)'(OUT_DEPTH));

    assign m_valid   = (count != '0);
    assign pop       = m_valid && m_ready;
    assign out_level = count;

    always_ff @(posedge rd_clk or negedge rd_rst) begin
        if (!rd_rst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
        end
    end

    fifo_out_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (OUT_DEPTH),
        .CNT_W      (CNT_W)
    ) u_out_buf (
        .rd_clk    (rd_clk),
        .rd_rst    (rd_rst),
        .push      (inflight),
        .push_data (mem_rdata),
        .pop       (pop),
        .count     (count),
        .head_data (m_data)
    );

    a_rd_en_not_empty: assert property (@(posedge rd_clk) disable iff (!rd_rst)
        fifo_rd_en |-> !fifo_empty);

    a_count_bound: assert property (@(posedge rd_clk) disable iff (!rd_rst)
        count <= CNT_W'(OUT_DEPTH));

    a_no_push_when_full: assert property (@(posedge rd_clk) disable iff (!rd_rst)
        inflight |-> (count != CNT_W'(OUT_DEPTH)));

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: a behavioural FIFO upstream with registered empty
// and 1-cycle RAM read, a directed vector table and scoreboarded sequences.
module tb_fifo_rd_stream;

    logic       rd_clk;
    logic       rd_rst;
    logic       fifo_empty;
    logic       fifo_rd_en;
    logic [7:0] mem_rdata;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic [1:0] out_level;

    logic [7:0] mem [2048];
    int         avail;
    int         rp;
    int         exp_idx;
    int         vectors;
    int         miscompares;

    typedef struct {
        int         add;
        bit         ready;
        bit         exp_rd_en;
        bit         exp_valid;
        logic [7:0] exp_data;
        logic [1:0] exp_level;
    } vec_t;

    vec_t vec [5];

    fifo_rd_stream dut (
        .rd_clk     (rd_clk),
        .rd_rst     (rd_rst),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .mem_rdata  (mem_rdata),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .out_level  (out_level)
    );

    initial rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    // Upstream model: registered empty flag, RAM data one cycle after rd_en.
    always @(posedge rd_clk or negedge rd_rst) begin
        if (!rd_rst) begin
            rp         <= 0;
            fifo_empty <= 1'b1;
            mem_rdata  <= 8'h00;
        end else begin
            if (fifo_rd_en) begin
                mem_rdata <= mem[rp];
            end
            rp         <= rp + (fifo_rd_en ? 1 : 0);
            fifo_empty <= ((rp + (fifo_rd_en ? 1 : 0)) >= avail);
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int add, input bit ready);
        avail   = avail + add;
        m_ready = ready;
        #1;
    endtask

    // One call per cycle starting at a negedge; accepted words go to the scoreboard.
    task automatic recvWords(input int n, input int budget, input bit rand_mode,
                             output int first_cyc, output int last_cyc);
        int   got;
        int   target;
        bit   prev_v;
        bit   prev_r;
        logic [7:0] prev_d;
        got       = 0;
        target    = exp_idx + n;
        prev_v    = 1'b0;
        prev_r    = 1'b0;
        prev_d    = 8'h00;
        first_cyc = -1;
        last_cyc  = -1;
        for (int cyc = 0; cyc < budget && got < n; cyc++) begin
            if (rand_mode) begin
                applyStimulus((avail < target && $urandom_range(1, 0) == 1) ? 1 : 0,
                              $urandom_range(1, 0) == 1);
            end else begin
                applyStimulus(0, 1'b1);
            end
            if (prev_v && !prev_r) begin
                checkOutput("stall_valid", int'(m_valid), 1);
                checkOutput("stall_data", int'(m_data), int'(prev_d));
            end
            if (m_valid && m_ready) begin
                checkOutput($sformatf("word[%0d]", exp_idx), int'(m_data), int'(mem[exp_idx]));
                exp_idx++;
                got++;
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
            end
            prev_v = m_valid;
            prev_r = m_ready;
            prev_d = m_data;
            @(negedge rd_clk);
        end
        checkOutput("recv_count", got, n);
    endtask

    initial begin
        int first_c;
        int last_c;
        int c;

        vectors     = 0;
        miscompares = 0;
        exp_idx     = 0;
        avail       = 0;
        m_ready     = 1'b0;
        rd_rst      = 1'b0;

        mem[0] = 8'hA5;
        for (int i = 0; i < 32; i++) mem[1 + i] = 8'(i);
        for (int i = 0; i < 10; i++) mem[33 + i] = 8'h40 + 8'(i);
        for (int i = 43; i < 2048; i++) mem[i] = 8'($urandom);

        // Single word 0xA5: empty drops after the first edge, rd_en one cycle, valid two later.
        vec[0] = '{add: 1, ready: 1'b1, exp_rd_en: 1'b0, exp_valid: 1'b0, exp_data: 8'h00, exp_level: 2'd0};
        vec[1] = '{add: 0, ready: 1'b1, exp_rd_en: 1'b1, exp_valid: 1'b0, exp_data: 8'h00, exp_level: 2'd0};
        vec[2] = '{add: 0, ready: 1'b1, exp_rd_en: 1'b0, exp_valid: 1'b0, exp_data: 8'h00, exp_level: 2'd0};
        vec[3] = '{add: 0, ready: 1'b1, exp_rd_en: 1'b0, exp_valid: 1'b1, exp_data: 8'hA5, exp_level: 2'd1};
        vec[4] = '{add: 0, ready: 1'b1, exp_rd_en: 1'b0, exp_valid: 1'b0, exp_data: 8'h00, exp_level: 2'd0};

        repeat (3) @(negedge rd_clk);
        #1;
        checkOutput("rst_valid", int'(m_valid), 0);
        checkOutput("rst_level", int'(out_level), 0);
        checkOutput("rst_rd_en", int'(fifo_rd_en), 0);
        @(negedge rd_clk);
        rd_rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 1'b0);
            checkOutput("idle_valid", int'(m_valid), 0);
            checkOutput("idle_rd_en", int'(fifo_rd_en), 0);
            checkOutput("idle_level", int'(out_level), 0);
            @(negedge rd_clk);
        end

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vec[i].add, vec[i].ready);
            checkOutput($sformatf("vec%0d_rd_en", i), int'(fifo_rd_en), int'(vec[i].exp_rd_en));
            checkOutput($sformatf("vec%0d_valid", i), int'(m_valid), int'(vec[i].exp_valid));
            checkOutput($sformatf("vec%0d_level", i), int'(out_level), int'(vec[i].exp_level));
            if (vec[i].exp_valid) begin
                checkOutput($sformatf("vec%0d_data", i), int'(m_data), int'(vec[i].exp_data));
            end
            @(negedge rd_clk);
        end
        exp_idx = 1;

        // Streaming 32 words with m_ready high: consecutive accepts with no gaps.
        avail = avail + 32;
        recvWords(32, 200, 1'b0, first_c, last_c);
        checkOutput("stream_span", last_c - first_c, 31);

        // Back-pressure: buffer fills to 3, reads stop, head word holds.
        for (int i = 0; i < 20; i++) begin
            applyStimulus((i == 0) ? 10 : 0, 1'b0);
            if (m_valid) begin
                checkOutput("bp_data", int'(m_data), int'(mem[33]));
            end
            @(negedge rd_clk);
        end
        applyStimulus(0, 1'b0);
        checkOutput("bp_level", int'(out_level), 3);
        checkOutput("bp_rd_en", int'(fifo_rd_en), 0);
        checkOutput("bp_valid", int'(m_valid), 1);
        checkOutput("bp_head", int'(m_data), int'(mem[33]));
        @(negedge rd_clk);
        recvWords(10, 200, 1'b0, first_c, last_c);

        // Random ready and random upstream arrivals over 1000 words.
        recvWords(1000, 20000, 1'b1, first_c, last_c);

        // Reset mid-operation with one word in flight and two buffered.
        c = 0;
        applyStimulus(5, 1'b0);
        while (out_level != 2'd2 && c < 50) begin
            @(negedge rd_clk);
            applyStimulus(0, 1'b0);
            c++;
        end
        checkOutput("pre_rst_level", int'(out_level), 2);
        rd_rst = 1'b0;
        avail  = 0;
        #1;
        checkOutput("async_rst_valid", int'(m_valid), 0);
        checkOutput("async_rst_level", int'(out_level), 0);
        checkOutput("async_rst_rd_en", int'(fifo_rd_en), 0);
        @(negedge rd_clk);
        @(negedge rd_clk);
        for (int i = 0; i < 8; i++) mem[i] = 8'hC0 + 8'(i);
        exp_idx = 0;
        rd_rst  = 1'b1;
        avail   = 8;
        recvWords(8, 100, 1'b0, first_c, last_c);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
